// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: instruction-fetch and load/store request/response channels
// shared between a CPU core (master) and the SRAM arbiter (slave).
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned LANES = DATA_W / 8;

    // Instruction-fetch channel (read only)
    logic              i_req_valid;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_req_ready;
    logic              i_rsp_valid;
    logic [DATA_W-1:0] i_rsp_data;
    logic              i_rsp_ready;

    // Load/store channel
    logic              d_req_valid;
    logic [ADDR_W-1:0] d_req_addr;
    logic [LANES-1:0]  d_req_wen;
    logic [DATA_W-1:0] d_req_wdata;
    logic              d_req_ready;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_data;
    logic              d_rsp_ready;

    // Requester side (core)
    modport master (
        output i_req_valid, i_req_addr, i_rsp_ready,
        output d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_rsp_ready,
        input  i_req_ready, i_rsp_valid, i_rsp_data,
        input  d_req_ready, d_rsp_valid, d_rsp_data
    );

    // Arbiter side
    modport slave (
        input  i_req_valid, i_req_addr, i_rsp_ready,
        input  d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_rsp_ready,
        output i_req_ready, i_rsp_valid, i_rsp_data,
        output d_req_ready, d_rsp_valid, d_rsp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported SRAM (combinational read) between an
// instruction-fetch port and a load/store port. One grant per cycle, read
// data captured at the grant edge, one-deep response slot per port.
// Build option ARB_ROUND_ROBIN_EN: when defined, conflicts alternate away
// from the last granted port; when undefined, the data port always wins.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_arbiter_if.slave          bus,
    output logic [DATA_W/8-1:0]   sram_w_en,
    output logic [ADDR_W-1:0]     sram_address,
    output logic [DATA_W-1:0]     sram_write_data,
    input  logic [DATA_W-1:0]     sram_read_data
);
    localparam int unsigned LANES = DATA_W / 8;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    grant_e            last_grant_q;
    grant_e            last_grant_d;

    logic              i_rsp_valid_q;
    logic [DATA_W-1:0] i_rsp_data_q;
    logic              d_rsp_valid_q;
    logic [DATA_W-1:0] d_rsp_data_q;

    logic [ADDR_W-1:0] addr_hold_q;
    logic [DATA_W-1:0] wdata_hold_q;

    logic              i_elig;
    logic              d_elig;
    logic              grant_i;
    logic              grant_d;

    // A port may be granted only if its response slot is free or draining now
    always_comb begin
        i_elig = bus.i_req_valid && (!i_rsp_valid_q || bus.i_rsp_ready);
        d_elig = bus.d_req_valid && (!d_rsp_valid_q || bus.d_rsp_ready);
    end

    // Grant-history register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_D;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // Arbitration and next grant-history; nothing is granted while in reset
    always_comb begin
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        last_grant_d = last_grant_q;
        if (rst_n) begin
            if (i_elig && d_elig) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (last_grant_q == GRANT_D) begin
                    grant_i = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
`else
                grant_d = 1'b1;
`endif
            end else if (i_elig) begin
                grant_i = 1'b1;
            end else if (d_elig) begin
                grant_d = 1'b1;
            end
        end
        if (grant_i) begin
            last_grant_d = GRANT_I;
        end else if (grant_d) begin
            last_grant_d = GRANT_D;
        end
    end

    // Ready goes only to the granted port, so it can never rise without valid
    assign bus.i_req_ready = grant_i;
    assign bus.d_req_ready = grant_d;

    // SRAM drive: granted request passes straight through, otherwise hold
    always_comb begin
        sram_w_en       = '0;
        sram_address    = addr_hold_q;
        sram_write_data = wdata_hold_q;
        if (grant_d) begin
            sram_w_en       = bus.d_req_wen;
            sram_address    = bus.d_req_addr;
            sram_write_data = bus.d_req_wdata;
        end else if (grant_i) begin
            sram_address    = bus.i_req_addr;
        end
    end

    // Remember the last driven address/data for idle cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else begin
            if (grant_d) begin
                addr_hold_q  <= bus.d_req_addr;
                wdata_hold_q <= bus.d_req_wdata;
            end else if (grant_i) begin
                addr_hold_q  <= bus.i_req_addr;
            end
        end
    end

    // Fetch response slot: fill on grant, clear on consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rsp_valid_q <= 1'b0;
            i_rsp_data_q  <= '0;
        end else if (grant_i) begin
            i_rsp_valid_q <= 1'b1;
            i_rsp_data_q  <= sram_read_data;
        end else if (i_rsp_valid_q && bus.i_rsp_ready) begin
            i_rsp_valid_q <= 1'b0;
        end
    end

    // Load/store response slot: stores acknowledge the same way as loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_rsp_valid_q <= 1'b0;
            d_rsp_data_q  <= '0;
        end else if (grant_d) begin
            d_rsp_valid_q <= 1'b1;
            d_rsp_data_q  <= sram_read_data;
        end else if (d_rsp_valid_q && bus.d_rsp_ready) begin
            d_rsp_valid_q <= 1'b0;
        end
    end

    assign bus.i_rsp_valid = i_rsp_valid_q;
    assign bus.i_rsp_data  = i_rsp_data_q;
    assign bus.d_rsp_valid = d_rsp_valid_q;
    assign bus.d_rsp_data  = d_rsp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus against mem_arbiter with a transaction
// model (expected memory image, response slots, grant history) checked on
// every falling clock edge, plus hand-computed literal expectations.
module tb_mem_arbiter;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WORDS  = 1 << (ADDR_W - 2);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic [3:0]        sram_w_en;
    logic [ADDR_W-1:0] sram_address;
    logic [DATA_W-1:0] sram_write_data;
    logic [DATA_W-1:0] sram_read_data;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .sram_w_en       (sram_w_en),
        .sram_address    (sram_address),
        .sram_write_data (sram_write_data),
        .sram_read_data  (sram_read_data)
    );

    // SRAM environment: combinational read, byte-lane write on rising edge
    logic [31:0] sram_mem [WORDS];
    assign sram_read_data = sram_mem[sram_address[ADDR_W-1:2]];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (sram_w_en[b]) sram_mem[sram_address[ADDR_W-1:2]][b*8 +: 8] <= sram_write_data[b*8 +: 8];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    logic [31:0] exp_mem [WORDS];
    logic        m_last;           // 1 = D granted last
    logic        m_iv, m_dv, m_dload;
    logic [31:0] m_id, m_dd, m_wdata;
    logic [15:0] m_addr;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] wen);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (wen[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Returns {d_granted, i_granted} from the model's view of the present cycle
    function automatic logic [1:0] model_grant();
        logic ie, de;
        if (!rst_n) return 2'b00;
        ie = bus.i_req_valid && (!m_iv || bus.i_rsp_ready);
        de = bus.d_req_valid && (!m_dv || bus.d_rsp_ready);
        if (ie && de) begin
`ifdef ARB_ROUND_ROBIN_EN
            return m_last ? 2'b01 : 2'b10;
`else
            return 2'b10;
`endif
        end
        return {de, ie};
    endfunction

    // Model state advance on each edge; async reset clears pending responses
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last  <= 1'b1;
            m_iv    <= 1'b0;
            m_dv    <= 1'b0;
            m_dload <= 1'b0;
            m_id    <= '0;
            m_dd    <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            if (model_grant() == 2'b01) begin
                m_iv   <= 1'b1;
                m_id   <= exp_mem[bus.i_req_addr[15:2]];
                m_last <= 1'b0;
                m_addr <= bus.i_req_addr;
            end else if (m_iv && bus.i_rsp_ready) begin
                m_iv <= 1'b0;
            end
            if (model_grant() == 2'b10) begin
                m_dv    <= 1'b1;
                m_dload <= (bus.d_req_wen == 4'b0000);
                m_dd    <= exp_mem[bus.d_req_addr[15:2]];
                exp_mem[bus.d_req_addr[15:2]] <= merge(exp_mem[bus.d_req_addr[15:2]], bus.d_req_wdata, bus.d_req_wen);
                m_last  <= 1'b1;
                m_addr  <= bus.d_req_addr;
                m_wdata <= bus.d_req_wdata;
            end else if (m_dv && bus.d_rsp_ready) begin
                m_dv <= 1'b0;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic [1:0] g;
        g = model_grant();
        chk("i_req_ready", 32'(bus.i_req_ready), 32'(g[0]));
        chk("d_req_ready", 32'(bus.d_req_ready), 32'(g[1]));
        chk("sram_w_en", 32'(sram_w_en), g[1] ? 32'(bus.d_req_wen) : 32'd0);
        chk("sram_address", 32'(sram_address),
            g[1] ? 32'(bus.d_req_addr) : (g[0] ? 32'(bus.i_req_addr) : 32'(m_addr)));
        chk("sram_write_data", sram_write_data, g[1] ? bus.d_req_wdata : m_wdata);
        chk("i_rsp_valid", 32'(bus.i_rsp_valid), 32'(m_iv));
        chk("d_rsp_valid", 32'(bus.d_rsp_valid), 32'(m_dv));
        if (m_iv) chk("i_rsp_data", bus.i_rsp_data, m_id);
        if (m_dv && m_dload) chk("d_rsp_data", bus.d_rsp_data, m_dd);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the chosen port is granted; returns just after the grant edge
    task automatic wait_ready(input logic is_d, input string nm);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = is_d ? bus.d_req_ready : bus.i_req_ready;
            tick();
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s actual=no_ready required=ready_within_20", nm);
        end
    endtask

    task automatic d_req(input logic [15:0] a, input logic [3:0] w, input logic [31:0] dt);
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = a;
        bus.d_req_wen   = w;
        bus.d_req_wdata = dt;
        wait_ready(1'b1, "d_req_wait");
        bus.d_req_valid = 1'b0;
    endtask

    task automatic i_req(input logic [15:0] a);
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = a;
        wait_ready(1'b0, "i_req_wait");
        bus.i_req_valid = 1'b0;
    endtask

    logic [1:0] rec   [6];
    logic [1:0] exp41 [6];

    initial begin
        bus.i_req_valid = 1'b0;
        bus.i_req_addr  = '0;
        bus.i_rsp_ready = 1'b1;
        bus.d_req_valid = 1'b0;
        bus.d_req_addr  = '0;
        bus.d_req_wen   = '0;
        bus.d_req_wdata = '0;
        bus.d_rsp_ready = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state, with requests pending so reset gating is exercised
        bus.d_req_valid = 1'b1;
        bus.d_req_wen   = 4'hF;
        bus.d_req_addr  = 16'h0050;
        bus.d_req_wdata = 32'h12345678;
        @(negedge clk);
        chk("rst_w_en", 32'(sram_w_en), 32'd0);
        chk("rst_addr", 32'(sram_address), 32'd0);
        chk("rst_wdata", sram_write_data, 32'd0);
        chk("rst_d_ready", 32'(bus.d_req_ready), 32'd0);
        chk("rst_i_rsp_valid", 32'(bus.i_rsp_valid), 32'd0);
        chk("rst_d_rsp_data", bus.d_rsp_data, 32'd0);
        tick();
        bus.d_req_valid = 1'b0;
        tick();
        rst_n = 1'b1;

        // Store then fetch the same word on the next cycle
        d_req(16'h0010, 4'hF, 32'hDEADBEEF);
        i_req(16'h0010);
        @(negedge clk);
        chk("rw_i_rsp_valid", 32'(bus.i_rsp_valid), 32'd1);
        chk("rw_i_rsp_data", bus.i_rsp_data, 32'hDEADBEEF);
        tick();

        // Both ports requesting continuously for six cycles
`ifdef ARB_ROUND_ROBIN_EN
        exp41[0] = 2'b10; exp41[1] = 2'b01; exp41[2] = 2'b10;
        exp41[3] = 2'b01; exp41[4] = 2'b10; exp41[5] = 2'b01;
`else
        for (int k = 0; k < 6; k++) exp41[k] = 2'b10;
`endif
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 16'h0010;
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = 16'h0010;
        bus.d_req_wen   = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rec[k] = {bus.d_req_ready, bus.i_req_ready};
            tick();
        end
        bus.i_req_valid = 1'b0;
        bus.d_req_valid = 1'b0;
        for (int k = 0; k < 6; k++) chk($sformatf("conflict_grant%0d", k), 32'(rec[k]), 32'(exp41[k]));
        tick();

        // Partial store over a full word, then load back
        d_req(16'h0020, 4'hF, 32'h11223344);
        d_req(16'h0020, 4'b0010, 32'h0000AB00);
        d_req(16'h0020, 4'b0000, 32'h0);
        @(negedge clk);
        chk("merge_d_rsp_valid", 32'(bus.d_rsp_valid), 32'd1);
        chk("merge_d_rsp_data", bus.d_rsp_data, 32'h1122AB44);
        tick();

        // Fetch response held back by the consumer while a new fetch waits
        bus.i_rsp_ready = 1'b0;
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 16'h0020;
        wait_ready(1'b0, "stall_first_grant");
        bus.i_req_addr  = 16'h0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_i_ready", 32'(bus.i_req_ready), 32'd0);
            chk("stall_i_rsp_valid", 32'(bus.i_rsp_valid), 32'd1);
            chk("stall_i_rsp_data", bus.i_rsp_data, 32'h1122AB44);
            tick();
        end
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        chk("drain_regrant", 32'(bus.i_req_ready), 32'd1);
        tick();
        bus.i_req_valid = 1'b0;
        @(negedge clk);
        chk("drain_new_data", bus.i_rsp_data, 32'hDEADBEEF);
        tick();

        // Reset between a store grant and its response
        d_req(16'h0030, 4'hF, 32'hCAFEF00D);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_d_rsp_valid", 32'(bus.d_rsp_valid), 32'd0);
        bus.d_req_valid = 1'b1;
        bus.d_req_addr  = 16'h0040;
        bus.d_req_wen   = 4'hF;
        bus.d_req_wdata = 32'h0BADF00D;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_mid_w_en", 32'(sram_w_en), 32'd0);
            chk("rst_mid_d_ready", 32'(bus.d_req_ready), 32'd0);
            tick();
        end
        bus.d_req_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Idle: nothing requested for five cycles
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("idle_w_en", 32'(sram_w_en), 32'd0);
            chk("idle_ready", 32'({bus.d_req_ready, bus.i_req_ready}), 32'd0);
            chk("idle_rsp_valid", 32'({bus.d_rsp_valid, bus.i_rsp_valid}), 32'd0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 16, SRAM byte-address width.
REQ-002 Parameter: DATA_W, 32, data width; fixed at 32, four byte lanes.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 i_req_valid  in  1  instruction-fetch read request.
REQ-006 i_req_addr  in  ADDR_W  fetch byte address.
REQ-007 i_req_ready  out  1  fetch request accepted this cycle.
REQ-008 i_rsp_valid  out  1  fetch data available.
REQ-009 i_rsp_data  out  32  fetch read data.
REQ-010 i_rsp_ready  in  1  fetch side consumes response.
REQ-011 d_req_valid  in  1  load/store request.
REQ-012 d_req_addr  in  ADDR_W  load/store byte address.
REQ-013 d_req_wen  in  4  byte-lane write enables; 0000 = load.
REQ-014 d_req_wdata  in  32  store data.
REQ-015 d_req_ready  out  1  load/store accepted this cycle.
REQ-016 d_rsp_valid  out  1  load data or store acknowledge available.
REQ-017 d_rsp_data  out  32  load data; undefined content for stores.
REQ-018 d_rsp_ready  in  1  data side consumes response.
REQ-019 sram_w_en  out  4  SRAM byte write enables.
REQ-020 sram_address  out  16  SRAM address.
REQ-021 sram_write_data  out  32  SRAM write data.
REQ-022 sram_read_data  in  32  SRAM combinational read data.

Function
REQ-023 A request transfers when valid and ready are both high on a rising edge; at most one port granted per cycle.
REQ-024 Port eligible when its valid is high and its response slot is free, or full and being consumed (rsp_valid and rsp_ready) in the same cycle.
REQ-025 Ready is asserted only to the granted port; ready never asserted while valid is low.
REQ-026 SRAM outputs driven combinationally from the granted request in the grant cycle; sram_w_en = d_req_wen only when D granted, otherwise 0000.
REQ-027 With no grant: sram_w_en = 0000, sram_address and sram_write_data hold their last driven values.
REQ-028 Granted port captures sram_read_data into its response register at the grant edge; rsp_valid rises the next cycle (latency 1).
REQ-029 rsp_valid and rsp_data hold stable until rsp_ready; response slot clears on consume unless refilled by a same-cycle grant.
REQ-030 Store response: d_rsp_valid asserted one cycle after acceptance, same handshake as loads.
REQ-031 Grant state register last_grant (I or D); updated on every grant.
REQ-032 Both eligible: arbitration per REQ-037/038; one eligible: that port granted; none: idle.
REQ-033 Addresses near 0xFFFF passed through unmodified; lane wrap is the SRAM's behaviour, not corrected here.
REQ-034 Request inputs of a non-granted port are ignored; the requester holds them until ready.

Reset
REQ-035 rst_n low asynchronously: i_rsp_valid=0, d_rsp_valid=0, rsp data regs=0, last_grant=D, sram outputs zero, all ready=0.
REQ-036 Reset mid-transaction discards pending responses; no SRAM write may occur during any cycle with rst_n low.

Configuration
REQ-037 Macro ARB_ROUND_ROBIN_EN defined: on conflict, port other than last_grant wins (strict alternation).
REQ-038 ARB_ROUND_ROBIN_EN undefined: on conflict, D port always wins (fixed priority); last_grant still tracked.

Verification
REQ-039 Reset, then D store addr 0x0010 wen 1111 data 0xDEADBEEF; next cycle I fetch 0x0010 -> i_rsp_data 0xDEADBEEF one cycle after i_req_ready.
REQ-040 Store wen 0010 data 0x0000AB00 over word 0x11223344 at 0x0020, then load -> 0x1122AB44.
REQ-041 Both ports valid continuously 6 cycles, rsp_ready=1: RR build -> grants D,I,D,I,D,I; fixed build -> D six times, i_req_ready never high.
REQ-042 I fetch accepted, i_rsp_ready=0 for 3 cycles while i_req_valid stays high -> i_req_ready low, i_rsp_data stable; rsp_ready high -> consume and new grant same cycle.
REQ-043 Assert rst_n low between D store grant and response -> d_rsp_valid=0 immediately, sram_w_en=0000 throughout reset.
REQ-044 No requests for 5 cycles -> sram_w_en=0000 every cycle, no ready, no rsp_valid.
